// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the RV32M multiply group. It retires one multiplier bit per clock.
// Operands are reduced to magnitudes at start, and the sign is reapplied to the full product on the last step.
`timescale 1ns/1ps
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mul_output
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_next;

  // A negated most-negative value wraps to itself, which is the correct unsigned magnitude.
  assign a_neg = a_signed & op_a[WIDTH-1];
  assign b_neg = b_signed & op_b[WIDTH-1];
  assign a_mag = a_neg ? ({WIDTH{1'b0}} - op_a) : op_a;
  assign b_mag = b_neg ? ({WIDTH{1'b0}} - op_b) : op_b;

  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + COUNT_ONE;
        if (count_q == LAST_COUNT) begin
          product_d = neg_q ? ({(2*WIDTH){1'b0}} - acc_next) : acc_next;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign mul_output = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: the driver queues reference products and a monitor checks each done pulse.
// It also checks latency, busy length, result hold, ignored starts and abort on reset.
`timescale 1ns/1ps
module tb_seq_multiplier;
  localparam int W = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic [W-1:0]    op_a, op_b;
  logic            a_signed, b_signed;
  logic            busy, done;
  logic [2*W-1:0]  mul_output;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [63:0]     exp_q[$];
  logic [63:0]     last_exp = 64'd0;
  logic [63:0]     mon_e;

  always #5 clock = ~clock;

  seq_multiplier #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .a_signed   (a_signed),
    .b_signed   (b_signed),
    .busy       (busy),
    .done       (done),
    .mul_output (mul_output)
  );

  // Reference: extend each operand per its signedness and take the low 2W bits of the product.
  function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b, logic as, logic bs);
    logic signed [63:0] xa, xb;
    xa = as ? {{32{a[31]}}, a} : {32'b0, a};
    xb = bs ? {{32{b[31]}}, b} : {32'b0, b};
    return 64'(xa * xb);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, expv);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with mul_output=0x%h, required no pending product", mul_output);
      end else begin
        mon_e    = exp_q.pop_front();
        last_exp = mon_e;
        $display("txn: mul_output=0x%h expected=0x%h", mul_output, mon_e);
        check("product", mul_output, mon_e);
      end
    end
  end

  // inject_at: cycle of RUN at which a spurious start is driven.
  // abort_at: cycle of RUN at which reset is asserted. A value of 0 disables either one.
  task automatic run_op(logic [31:0] a, logic [31:0] b, logic as, logic bs,
                        int inject_at, int abort_at);
    int  lat;
    int  busy_cnt;
    bit  got;
    bit  saw_done;
    @(negedge clock);
    op_a = a; op_b = b; a_signed = as; b_signed = bs; start = 1'b1;
    exp_q.push_back(ref_mul(a, b, as, bs));
    @(posedge clock); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; a_signed = 1'($urandom); b_signed = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (abort_at == i) begin
        reset = 1'b1;
        #1;
        check("abort_mul_output", mul_output, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(posedge clock); #1;
          if (done) saw_done = 1'b1;
        end
        check("no_done_after_abort", 64'(saw_done), 64'd0);
        return;
      end
      if (done && !got) begin
        lat = i;
        got = 1'b1;
      end
      if (busy) busy_cnt++;
      else break;
      if (inject_at == i) begin
        op_a = $urandom; op_b = $urandom; a_signed = 1'b1; b_signed = 1'b1;
        start = 1'b1;
      end
    end
    check("done_latency", 64'(lat), 64'd32);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
  endtask

  task automatic hold_check(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check("hold_mul_output", mul_output, last_exp);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; a_signed = 1'b0; b_signed = 1'b0;
    #1;
    check("reset_mul_output", mul_output, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op(32'd3, 32'd5, 1'b0, 1'b0, 0, 0);
    hold_check(3);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);
    run_op(32'hFFFF_FFF9, 32'd3, 1'b1, 1'b1, 0, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0);
    run_op(32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 0);
    run_op(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 0, 0);

    run_op(32'd3, 32'd5, 1'b0, 1'b0, 10, 0);
    hold_check(5);

    run_op(32'd3, 32'd5, 1'b0, 1'b0, 0, 0);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 0, 15);
    run_op(32'd7, 32'hFFFF_FFF7, 1'b0, 1'b1, 0, 0);

    for (int t = 0; t < 30; t++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom), 0, 0);
    end

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier for the RV32M multiply group (MUL/MULH/MULHSU/MULHU).
- Sits in the execute stage directly upstream of the 64-bit MUL result register.
- Drives the full 64-bit product on `mul_output`. Downstream logic selects the low or high word.
- Processes one multiplier bit per clock, with fixed latency and a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH bits.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs
- start  input  1  one-cycle request; accepted only in IDLE
- op_a  input  WIDTH  multiplicand (rs1)
- op_b  input  WIDTH  multiplier (rs2)
- a_signed  input  1  treat op_a as two's complement (MUL, MULH, MULHSU)
- b_signed  input  1  treat op_b as two's complement (MUL, MULH)
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle result-valid pulse
- mul_output  output  2*WIDTH  signed/unsigned product; held until the next completion

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, mul_output=0, all internal registers=0. Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE, on a clock edge with start=1:
  - Latch mcand = magnitude of op_a, extended to 2*WIDTH. Negate only if a_signed & op_a[WIDTH-1].
  - Latch mplier = magnitude of op_b. Negate only if b_signed & op_b[WIDTH-1].
  - Latch neg = (a_signed & op_a[WIDTH-1]) ^ (b_signed & op_b[WIDTH-1]).
  - Set acc=0, count=0, then go to RUN.
- Magnitude of the most-negative value (0x80000000) is 0x80000000, read as unsigned. This must work without overflow.
- RUN, each edge:
  - If mplier[0], acc += mcand (2*WIDTH-bit add; no carry out is possible).
  - mcand <<= 1; mplier >>= 1; count += 1.
  - On the edge where count == WIDTH-1, the last bit is processed. On that edge:
    - mul_output <= neg ? -(acc_next) : acc_next, using two's complement on 2*WIDTH bits.
    - state <= DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge E0, mul_output updated and done high after edge E_WIDTH (32 cycles for WIDTH=32). Next start is accepted at edge E_WIDTH+2 at the earliest.
- start while busy (RUN or DONE) is ignored. Operands are not re-latched and in-flight state is not disturbed.
- op_a/op_b/a_signed/b_signed only need to be valid in the cycle start is sampled.
- mul_output changes only at completion or reset. It is stable between done pulses.
- Signed×unsigned (MULHSU: a_signed=1, b_signed=0) uses op_b raw as unsigned.
- a_signed=0, b_signed=1 is legal and symmetric.
- Zero operands run the full WIDTH cycles; there is no early termination.

Test Plan:
- Unsigned 3×5 (a_signed=b_signed=0) -> done exactly 32 cycles after start; mul_output=0x000000000000000F; busy high for 33 cycles.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE00000001.
- Signed -7 (0xFFFFFFF9) × 3 -> 0xFFFFFFFFFFFFFFEB; signed 0x80000000×0x80000000 -> 0x4000000000000000; signed -1×-1 -> 0x0000000000000001.
- MULHSU: op_a=0xFFFFFFFF (a_signed=1), op_b=0xFFFFFFFF (b_signed=0) -> 0xFFFFFFFF00000001.
- Start pulsed again at cycle 10 of RUN with different operands -> ignored; original product delivered at cycle 32. mul_output is held through the following idle cycles until the next done.
- Complete one product (mul_output=0xF), start a new one, assert reset at cycle 15 of RUN -> mul_output=0, busy=0, done never pulses. A fresh start after reset release yields the correct result on schedule.
